// File: rtl/collision_arbiter_if.sv
// Bus bundle between the collision arbiter, its requesters and the map lookup.
// The master side is the environment (requesters plus map); the slave side is the arbiter.
interface collision_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [10*NUM_REQ-1:0] req_x;
  logic [10*NUM_REQ-1:0] req_y;
  logic [1:0]            level_id;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic                  rsp_wall;
  logic                  busy;
  logic [9:0]            col_x;
  logic [9:0]            col_y;
  logic [1:0]            col_level;
  logic                  col_is_wall;

  modport master (
    output req, req_x, req_y, level_id, col_is_wall,
    input  gnt, rsp_valid, rsp_wall, busy, col_x, col_y, col_level
  );

  modport slave (
    input  req, req_x, req_y, level_id, col_is_wall,
    output gnt, rsp_valid, rsp_wall, busy, col_x, col_y, col_level
  );
endinterface

// File: rtl/collision_arbiter.sv
// Round-robin arbiter sharing one collision map lookup port among NUM_REQ requesters,
// returning each wall bit with a single-cycle valid pulse to the requester it belongs to.
module collision_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LOOKUP_LAT = 0
) (
  input  logic                clk,
  input  logic                rst,
  collision_arbiter_if.slave  bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (LOOKUP_LAT > 0) ? $clog2(LOOKUP_LAT + 1) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_wall_q, rsp_wall_d;
  logic               busy_q, busy_d;
  logic [9:0]         col_x_q, col_x_d;
  logic [9:0]         col_y_q, col_y_d;
  logic [1:0]         col_level_q, col_level_d;

  logic [NUM_REQ-1:0] eligible_s;
  logic               win_found_s;
  logic [PW-1:0]      win_idx_s;
  logic [PW:0]        scan_sum_s;
  logic [PW-1:0]      scan_idx_s;

  // Round-robin winner search starting at ptr; the requester answered this cycle is masked.
  always_comb begin
    eligible_s  = bus.req & ~rsp_valid_q;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_sum_s  = '0;
    scan_idx_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum_s = {1'b0, ptr_q} + (PW+1)'(k);
      if (scan_sum_s >= (PW+1)'(NUM_REQ)) begin
        scan_sum_s = scan_sum_s - (PW+1)'(NUM_REQ);
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = scan_sum_s[PW-1:0];
      if (!win_found_s && eligible_s[scan_idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and next-output computation for the IDLE/WAIT controller.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_wall_d  = rsp_wall_q;
    busy_d      = busy_q;
    col_x_d     = col_x_q;
    col_y_d     = col_y_q;
    col_level_d = col_level_q;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          gnt_d = '0;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx_s == PW'(i)) begin
              col_x_d  = bus.req_x[10*i +: 10];
              col_y_d  = bus.req_y[10*i +: 10];
              gnt_d[i] = 1'b1;
            end else begin
              gnt_d[i] = 1'b0;
            end
          end
          col_level_d = bus.level_id;
          busy_d      = 1'b1;
          cnt_d       = '0;
          // Explicit wrap keeps ptr inside 0..NUM_REQ-1 for non-power-of-2 counts.
          if (win_idx_s == PW'(NUM_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = win_idx_s + PW'(1'b1);
          end
          state_d = WAIT;
        end else begin
          gnt_d = '0;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(LOOKUP_LAT)) begin
          rsp_wall_d  = bus.col_is_wall;
          rsp_valid_d = gnt_q;
          gnt_d       = '0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight lookup without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_wall_q  <= 1'b0;
      busy_q      <= 1'b0;
      col_x_q     <= 10'd0;
      col_y_q     <= 10'd0;
      col_level_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wall_q  <= rsp_wall_d;
      busy_q      <= busy_d;
      col_x_q     <= col_x_d;
      col_y_q     <= col_y_d;
      col_level_q <= col_level_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_wall  = rsp_wall_q;
  assign bus.busy      = busy_q;
  assign bus.col_x     = col_x_q;
  assign bus.col_y     = col_y_q;
  assign bus.col_level = col_level_q;
endmodule

// File: tb/tb_collision_arbiter.sv
// Self-checking bench for collision_arbiter: one instance with a combinational map, one with
// a two-cycle map; expected responses are queued at grant time and popped on rsp_valid.
module tb_collision_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  collision_arbiter_if #(.NUM_REQ(4)) b0 ();
  collision_arbiter_if #(.NUM_REQ(4)) b2 ();

  collision_arbiter #(.NUM_REQ(4), .LOOKUP_LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  collision_arbiter #(.NUM_REQ(4), .LOOKUP_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    logic [3:0] who;
    logic       wall;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    b0.req = 4'b0000;
    b2.req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    q2.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b0.req = 4'b0000; b0.req_x = 40'd0; b0.req_y = 40'd0; b0.level_id = 2'd0; b0.col_is_wall = 1'b0;
    b2.req = 4'b0000; b2.req_x = 40'd0; b2.req_y = 40'd0; b2.level_id = 2'd0; b2.col_is_wall = 1'b0;
    #12;
    vectors++;
    if ({b0.gnt, b0.rsp_valid, b0.rsp_wall, b0.busy, b0.col_x, b0.col_y, b0.col_level} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_dut0: gnt=%b rsp_valid=%b wall=%b busy=%b col_x=%0d col_y=%0d lvl=%0d, all required 0",
               b0.gnt, b0.rsp_valid, b0.rsp_wall, b0.busy, b0.col_x, b0.col_y, b0.col_level);
    end
    vectors++;
    if ({b2.gnt, b2.rsp_valid, b2.rsp_wall, b2.busy, b2.col_x, b2.col_y, b2.col_level} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_dut2: gnt=%b rsp_valid=%b busy=%b col_x=%0d, all required 0",
               b2.gnt, b2.rsp_valid, b2.busy, b2.col_x);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    exp_t e;
    b0.req_x[9:0] = 10'd160;
    b0.req_y[9:0] = 10'd224;
    b0.col_is_wall = 1'b0;
    b0.req = 4'b0001;
    tick();
    vectors++;
    if (b0.gnt !== 4'b0001 || b0.col_x !== 10'd160 || b0.col_y !== 10'd224 || b0.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant: gnt=%b col_x=%0d col_y=%0d busy=%b, required 0001/160/224/1",
               b0.gnt, b0.col_x, b0.col_y, b0.busy);
    end
    q0.push_back('{who: 4'b0001, wall: 1'b0});
    b0.req_x[9:0] = 10'd5;
    tick();
    vectors++;
    if (q0.size() == 0) begin
      miscompares++;
      $display("FAIL single_rsp: scoreboard empty, rsp_valid=%b", b0.rsp_valid);
    end else begin
      e = q0.pop_front();
      if (b0.rsp_valid !== e.who || b0.rsp_wall !== e.wall || b0.gnt !== 4'b0000) begin
        miscompares++;
        $display("FAIL single_rsp: rsp_valid=%b wall=%b gnt=%b, required %b/%b/0000",
                 b0.rsp_valid, b0.rsp_wall, b0.gnt, e.who, e.wall);
      end
    end
    vectors++;
    if (b0.col_x !== 10'd160) begin
      miscompares++;
      $display("FAIL single_hold_x: col_x=%0d, required 160", b0.col_x);
    end
    b0.req = 4'b0000;
    tick();
    vectors++;
    if (b0.rsp_valid !== 4'b0000 || b0.gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_pulse_end: rsp_valid=%b gnt=%b, required 0000/0000", b0.rsp_valid, b0.gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_t e;
    do_reset();
    b0.col_is_wall = 1'b1;
    b0.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (b0.gnt !== seq[i] || b0.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL rr_grant%0d: gnt=%b busy=%b, required %b/1", i, b0.gnt, b0.busy, seq[i]);
      end
      q0.push_back('{who: seq[i], wall: 1'b1});
      tick();
      vectors++;
      if (q0.size() == 0) begin
        miscompares++;
        $display("FAIL rr_rsp%0d: scoreboard empty, rsp_valid=%b", i, b0.rsp_valid);
      end else begin
        e = q0.pop_front();
        if (b0.rsp_valid !== e.who || b0.rsp_wall !== e.wall || b0.gnt !== 4'b0000) begin
          miscompares++;
          $display("FAIL rr_rsp%0d: rsp_valid=%b wall=%b gnt=%b, required %b/%b/0000",
                   i, b0.rsp_valid, b0.rsp_wall, b0.gnt, e.who, e.wall);
        end
      end
    end
    b0.req = 4'b0000;
  endtask

  task automatic test_simultaneous();
    logic [3:0] reqs [3] = '{4'b0010, 4'b0101, 4'b0001};
    logic [3:0] seq  [3] = '{4'b0010, 4'b0100, 4'b0001};
    exp_t e;
    b0.col_is_wall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b0.req = reqs[i];
      tick();
      vectors++;
      if (b0.gnt !== seq[i]) begin
        miscompares++;
        $display("FAIL simul_grant%0d: gnt=%b, required %b", i, b0.gnt, seq[i]);
      end
      q0.push_back('{who: seq[i], wall: 1'b0});
      tick();
      vectors++;
      if (q0.size() == 0) begin
        miscompares++;
        $display("FAIL simul_rsp%0d: scoreboard empty, rsp_valid=%b", i, b0.rsp_valid);
      end else begin
        e = q0.pop_front();
        if (b0.rsp_valid !== e.who || b0.rsp_wall !== e.wall) begin
          miscompares++;
          $display("FAIL simul_rsp%0d: rsp_valid=%b wall=%b, required %b/%b",
                   i, b0.rsp_valid, b0.rsp_wall, e.who, e.wall);
        end
      end
    end
    b0.req = 4'b0000;
  endtask

  task automatic test_latency2();
    exp_t e;
    b2.req_x[19:10] = 10'd32;
    b2.req_y[19:10] = 10'd64;
    b2.col_is_wall = 1'b0;
    b2.req = 4'b0010;
    tick();
    vectors++;
    if (b2.gnt !== 4'b0010 || b2.col_x !== 10'd32 || b2.col_y !== 10'd64 || b2.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL lat2_grant: gnt=%b col_x=%0d col_y=%0d busy=%b, required 0010/32/64/1",
               b2.gnt, b2.col_x, b2.col_y, b2.busy);
    end
    q2.push_back('{who: 4'b0010, wall: 1'b1});
    for (int c = 2; c <= 3; c++) begin
      tick();
      vectors++;
      if (b2.busy !== 1'b1 || b2.rsp_valid !== 4'b0000) begin
        miscompares++;
        $display("FAIL lat2_wait_T%0d: busy=%b rsp_valid=%b, required 1/0000", c, b2.busy, b2.rsp_valid);
      end
    end
    b2.col_is_wall = 1'b1;
    tick();
    vectors++;
    if (q2.size() == 0) begin
      miscompares++;
      $display("FAIL lat2_rsp: scoreboard empty, rsp_valid=%b", b2.rsp_valid);
    end else begin
      e = q2.pop_front();
      if (b2.rsp_valid !== e.who || b2.rsp_wall !== e.wall || b2.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL lat2_rsp: rsp_valid=%b wall=%b busy=%b, required %b/%b/0",
                 b2.rsp_valid, b2.rsp_wall, b2.busy, e.who, e.wall);
      end
    end
    b2.req = 4'b0000;
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    b2.req_x[9:0] = 10'd77;
    b2.col_is_wall = 1'b1;
    b2.req = 4'b0001;
    tick();
    vectors++;
    if (b2.gnt !== 4'b0001 || b2.col_x !== 10'd77) begin
      miscompares++;
      $display("FAIL midrst_grant: gnt=%b col_x=%0d, required 0001/77", b2.gnt, b2.col_x);
    end
    b2.req = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (b2.gnt !== 4'b0000 || b2.busy !== 1'b0 || b2.col_x !== 10'd0) begin
      miscompares++;
      $display("FAIL midrst_async: gnt=%b busy=%b col_x=%0d, required 0000/0/0", b2.gnt, b2.busy, b2.col_x);
    end
    q2.delete();
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (b2.rsp_valid !== 4'b0000 || b2.gnt !== 4'b0000) begin
        miscompares++;
        $display("FAIL midrst_quiet%0d: rsp_valid=%b gnt=%b, required 0000/0000", c, b2.rsp_valid, b2.gnt);
      end
    end
    b2.col_is_wall = 1'b0;
    b2.req = 4'b0011;
    tick();
    vectors++;
    if (b2.gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL midrst_ptr: gnt=%b, required 0001", b2.gnt);
    end
    q2.push_back('{who: 4'b0001, wall: 1'b0});
    tick();
    tick();
    vectors++;
    if (b2.rsp_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrst_early: rsp_valid=%b, required 0000", b2.rsp_valid);
    end
    tick();
    vectors++;
    if (q2.size() == 0) begin
      miscompares++;
      $display("FAIL midrst_rsp: scoreboard empty, rsp_valid=%b", b2.rsp_valid);
    end else begin
      e = q2.pop_front();
      if (b2.rsp_valid !== e.who || b2.rsp_wall !== e.wall) begin
        miscompares++;
        $display("FAIL midrst_rsp: rsp_valid=%b wall=%b, required %b/%b", b2.rsp_valid, b2.rsp_wall, e.who, e.wall);
      end
    end
    b2.req = 4'b0000;
  endtask

  task automatic test_back_to_back_same();
    exp_t e;
    b0.col_is_wall = 1'b1;
    b0.level_id = 2'd1;
    b0.req = 4'b1000;
    tick();
    vectors++;
    if (b0.gnt !== 4'b1000 || b0.col_level !== 2'd1) begin
      miscompares++;
      $display("FAIL b2b_grant1: gnt=%b col_level=%0d, required 1000/1", b0.gnt, b0.col_level);
    end
    q0.push_back('{who: 4'b1000, wall: 1'b1});
    tick();
    vectors++;
    if (q0.size() == 0) begin
      miscompares++;
      $display("FAIL b2b_rsp1: scoreboard empty, rsp_valid=%b", b0.rsp_valid);
    end else begin
      e = q0.pop_front();
      if (b0.rsp_valid !== e.who || b0.rsp_wall !== e.wall) begin
        miscompares++;
        $display("FAIL b2b_rsp1: rsp_valid=%b wall=%b, required %b/%b", b0.rsp_valid, b0.rsp_wall, e.who, e.wall);
      end
    end
    tick();
    vectors++;
    if (b0.gnt !== 4'b0000 || b0.rsp_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL b2b_masked: gnt=%b rsp_valid=%b, required 0000/0000", b0.gnt, b0.rsp_valid);
    end
    b0.level_id = 2'd2;
    tick();
    vectors++;
    if (b0.gnt !== 4'b1000 || b0.col_level !== 2'd2) begin
      miscompares++;
      $display("FAIL b2b_grant2: gnt=%b col_level=%0d, required 1000/2", b0.gnt, b0.col_level);
    end
    q0.push_back('{who: 4'b1000, wall: 1'b1});
    tick();
    vectors++;
    if (q0.size() == 0) begin
      miscompares++;
      $display("FAIL b2b_rsp2: scoreboard empty, rsp_valid=%b", b0.rsp_valid);
    end else begin
      e = q0.pop_front();
      if (b0.rsp_valid !== e.who || b0.rsp_wall !== e.wall) begin
        miscompares++;
        $display("FAIL b2b_rsp2: rsp_valid=%b wall=%b, required %b/%b", b0.rsp_valid, b0.rsp_wall, e.who, e.wall);
      end
    end
    b0.req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_simultaneous();
    test_latency2();
    test_reset_midflight();
    test_back_to_back_same();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
